// File: rtl/float_round_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : float_round_arbiter
// Description : Round-robin arbiter feeding a two-stage round-to-nearest-even
//               pipeline for unrounded floats (capture stage S1, result S2).
// Revision    : 1.0 - initial release
// ============================================================================
module float_round_arbiter #(
    parameter int EXP     = 8,
    parameter int FRAC    = 23,
    parameter int NUM_REQ = 4
) (
    input  logic                              clock,
    input  logic                              resetn,
    input  logic [NUM_REQ-1:0]                in_valid,
    output logic [NUM_REQ-1:0]                in_ready,
    input  logic [NUM_REQ*(1+EXP+FRAC)-1:0]   in_data,
    input  logic [NUM_REQ*2-1:0]              in_trailing,
    input  logic [NUM_REQ-1:0]                in_sticky,
    input  logic [NUM_REQ-1:0]                in_is_nan,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [EXP+FRAC:0]                 out_data,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] out_id
);

    localparam int c_W   = 1 + EXP + FRAC;
    localparam int c_M   = EXP + FRAC;
    localparam int c_IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [c_W-1:0]   w_req_data  [NUM_REQ];
    logic [1:0]       w_req_trail [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_req_data[gi]  = in_data[gi*c_W +: c_W];
        assign w_req_trail[gi] = in_trailing[gi*2 +: 2];
    end

    logic             r_s1_valid_q, w_s1_valid_d;
    logic [c_W-1:0]   r_s1_data_q,  w_s1_data_d;
    logic [1:0]       r_s1_trail_q, w_s1_trail_d;
    logic             r_s1_sticky_q, w_s1_sticky_d;
    logic             r_s1_nan_q,   w_s1_nan_d;
    logic [c_IDW-1:0] r_s1_id_q,    w_s1_id_d;
    logic             r_s2_valid_q, w_s2_valid_d;
    logic [c_W-1:0]   r_s2_data_q,  w_s2_data_d;
    logic [c_IDW-1:0] r_s2_id_q,    w_s2_id_d;
    logic [c_IDW-1:0] r_ptr_q,      w_ptr_d;

    logic             w_grant_found;
    logic [c_IDW-1:0] w_grant_idx;
    logic [c_IDW:0]   w_cand_wide;
    logic [c_IDW-1:0] w_cand;
    logic             w_s1_to_s2;
    logic             w_s1_accept;
    logic             w_take;
    logic [NUM_REQ-1:0] w_in_ready;

    // Search starts at the pointer and wraps; first valid candidate wins.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_cand_wide   = '0;
        w_cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand_wide = {1'b0, r_ptr_q} + (c_IDW+1)'(k);
            if (w_cand_wide >= (c_IDW+1)'(NUM_REQ)) begin
                w_cand_wide = w_cand_wide - (c_IDW+1)'(NUM_REQ);
            end
            w_cand = w_cand_wide[c_IDW-1:0];
            if (!w_grant_found && in_valid[w_cand]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_cand;
            end
        end
    end

    assign w_s1_to_s2  = r_s1_valid_q & (~r_s2_valid_q | out_ready);
    assign w_s1_accept = resetn & (~r_s1_valid_q | w_s1_to_s2);
    assign w_take      = w_s1_accept & w_grant_found;

    always_comb begin
        w_in_ready = '0;
        if (w_take) begin
            w_in_ready[w_grant_idx] = 1'b1;
        end
    end

    assign in_ready = w_in_ready;

    logic             w_round_up;
    logic [c_M-1:0]   w_sum;
    logic [EXP-1:0]   w_exp_out;
    logic [FRAC-1:0]  w_frac_out;
    logic [c_W-1:0]   w_rounded;

    // Carry out of the fraction flows naturally into the exponent field.
    assign w_round_up = r_s1_trail_q[1] & (r_s1_trail_q[0] | r_s1_sticky_q | r_s1_data_q[0]);
    assign w_sum      = r_s1_data_q[c_M-1:0] + {{(c_M-1){1'b0}}, w_round_up};
    assign w_exp_out  = w_sum[c_M-1:FRAC];

    always_comb begin
        w_frac_out = w_sum[FRAC-1:0];
        if (r_s1_nan_q) begin
            w_frac_out = r_s1_data_q[FRAC-1:0];
        end else if (&w_exp_out) begin
            w_frac_out = '0;
        end
    end

    assign w_rounded = {r_s1_data_q[c_W-1], w_exp_out, w_frac_out};

    always_comb begin
        w_s1_valid_d  = w_take | (r_s1_valid_q & ~w_s1_to_s2);
        w_s1_data_d   = r_s1_data_q;
        w_s1_trail_d  = r_s1_trail_q;
        w_s1_sticky_d = r_s1_sticky_q;
        w_s1_nan_d    = r_s1_nan_q;
        w_s1_id_d     = r_s1_id_q;
        w_ptr_d       = r_ptr_q;
        if (w_take) begin
            w_s1_data_d   = w_req_data[w_grant_idx];
            w_s1_trail_d  = w_req_trail[w_grant_idx];
            w_s1_sticky_d = in_sticky[w_grant_idx];
            w_s1_nan_d    = in_is_nan[w_grant_idx];
            w_s1_id_d     = w_grant_idx;
            w_ptr_d       = (w_grant_idx == c_IDW'(NUM_REQ-1)) ? '0
                                                             : w_grant_idx + c_IDW'(1);
        end
        w_s2_valid_d = w_s1_to_s2 | (r_s2_valid_q & ~out_ready);
        w_s2_data_d  = w_s1_to_s2 ? w_rounded : r_s2_data_q;
        w_s2_id_d    = w_s1_to_s2 ? r_s1_id_q : r_s2_id_q;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_s1_valid_q  <= 1'b0;
            r_s1_data_q   <= '0;
            r_s1_trail_q  <= '0;
            r_s1_sticky_q <= 1'b0;
            r_s1_nan_q    <= 1'b0;
            r_s1_id_q     <= '0;
            r_s2_valid_q  <= 1'b0;
            r_s2_data_q   <= '0;
            r_s2_id_q     <= '0;
            r_ptr_q       <= '0;
        end else begin
            r_s1_valid_q  <= w_s1_valid_d;
            r_s1_data_q   <= w_s1_data_d;
            r_s1_trail_q  <= w_s1_trail_d;
            r_s1_sticky_q <= w_s1_sticky_d;
            r_s1_nan_q    <= w_s1_nan_d;
            r_s1_id_q     <= w_s1_id_d;
            r_s2_valid_q  <= w_s2_valid_d;
            r_s2_data_q   <= w_s2_data_d;
            r_s2_id_q     <= w_s2_id_d;
            r_ptr_q       <= w_ptr_d;
        end
    end

    // Outputs read as zero while reset is asserted, not only after its edge.
    assign out_valid = r_s2_valid_q & resetn;
    assign out_data  = resetn ? r_s2_data_q : '0;
    assign out_id    = resetn ? r_s2_id_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_float_round_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_float_round_arbiter
// Description : Self-checking bench: vector table, directed pipeline corner
//               sequences and randomized traffic against a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_float_round_arbiter;

    logic         clock;
    logic         resetn;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [127:0] in_data;
    logic [7:0]   in_trailing;
    logic [3:0]   in_sticky;
    logic [3:0]   in_is_nan;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_id;

    float_round_arbiter #(.EXP(8), .FRAC(23), .NUM_REQ(4)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_trailing (in_trailing),
        .in_sticky   (in_sticky),
        .in_is_nan   (in_is_nan),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_id      (out_id)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  trail;
        logic        sticky;
        logic        nan;
        logic [31:0] expect_data;
    } vec_t;

    vec_t vecs[10];

    typedef struct {
        logic [31:0] data;
        logic [1:0]  id;
    } txn_t;

    txn_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic set_req(input int r, input logic [31:0] d, input logic [1:0] t,
                           input logic s, input logic n);
        in_data[r*32 +: 32]   = d;
        in_trailing[r*2 +: 2] = t;
        in_sticky[r]          = s;
        in_is_nan[r]          = n;
    endtask

    // Rounding computed on the magnitude as a plain integer.
    function automatic logic [31:0] ref_round(input logic [31:0] d, input logic [1:0] t,
                                              input logic s, input logic n);
        longint unsigned mag;
        longint unsigned e;
        longint unsigned f;
        bit up;
        up  = t[1] && (t[0] || s || d[0]);
        mag = 64'(d[30:0]) + (up ? 64'd1 : 64'd0);
        mag = mag % 64'h8000_0000;
        e   = mag / 64'd8388608;
        f   = mag % 64'd8388608;
        if (n) f = 64'(d[22:0]);
        else if (e == 64'd255) f = 64'd0;
        return {d[31], e[7:0], f[22:0]};
    endfunction

    task automatic do_reset(input bit chk);
        resetn   = 1'b0;
        in_valid = 4'hF;
        tick();
        settle();
        if (chk) begin
            check("reset_in_ready", 32'(in_ready), 32'h0);
            check("reset_out_valid", 32'(out_valid), 32'h0);
            check("reset_out_data", out_data, 32'h0);
            check("reset_out_id", 32'(out_id), 32'h0);
        end
        tick();
        resetn   = 1'b1;
        in_valid = 4'h0;
    endtask

    logic [3:0]  pv;
    logic [31:0] pd [4];
    logic [1:0]  pt [4];
    logic        ps [4];
    logic        pn [4];

    initial begin
        int grants;
        logic [31:0] held;
        int ptr;
        int g;
        int c;
        bit found;
        bit accept;
        bit prev_stall;
        logic [31:0] prev_data;
        logic [1:0]  prev_id;
        logic [3:0]  exp_ready;
        txn_t t;

        resetn      = 1'b0;
        in_valid    = '0;
        in_data     = '0;
        in_trailing = '0;
        in_sticky   = '0;
        in_is_nan   = '0;
        out_ready   = 1'b1;

        vecs[0] = '{32'h3F800001, 2'b10, 1'b0, 1'b0, 32'h3F800002};
        vecs[1] = '{32'h3F800000, 2'b10, 1'b0, 1'b0, 32'h3F800000};
        vecs[2] = '{32'h7F7FFFFF, 2'b11, 1'b0, 1'b0, 32'h7F800000};
        vecs[3] = '{32'h7FC00000, 2'b11, 1'b0, 1'b1, 32'h7FC00000};
        vecs[4] = '{32'h3FFFFFFF, 2'b10, 1'b0, 1'b0, 32'h40000000};
        vecs[5] = '{32'h3F800000, 2'b10, 1'b1, 1'b0, 32'h3F800001};
        vecs[6] = '{32'hBF800001, 2'b01, 1'b1, 1'b0, 32'hBF800001};
        vecs[7] = '{32'h007FFFFF, 2'b10, 1'b1, 1'b0, 32'h00800000};
        vecs[8] = '{32'hC07FFFFF, 2'b11, 1'b0, 1'b0, 32'hC0800000};
        vecs[9] = '{32'h7F800001, 2'b11, 1'b0, 1'b1, 32'h7F800001};

        do_reset(1'b1);

        // Single requests through an empty pipe: two-cycle latency.
        for (int i = 0; i < 10; i++) begin
            set_req(i % 4, vecs[i].data, vecs[i].trail, vecs[i].sticky, vecs[i].nan);
            in_valid = 4'(1) << (i % 4);
            settle();
            check("vec_in_ready", 32'(in_ready), 32'(4'(1) << (i % 4)));
            tick();
            in_valid = 4'h0;
            settle();
            check("vec_early_valid", 32'(out_valid), 32'h0);
            tick();
            settle();
            check("vec_out_valid", 32'(out_valid), 32'h1);
            check("vec_out_data", out_data, vecs[i].expect_data);
            check("vec_out_id", 32'(out_id), 32'(i % 4));
            tick();
        end

        // All four valid with downstream always ready.
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) set_req(i, 32'h3F800000 + 32'(i * 16), 2'b00, 1'b0, 1'b0);
        in_valid = 4'hF;
        for (int k = 0; k < 7; k++) begin
            settle();
            check("rr_in_ready", 32'(in_ready), 32'(4'(1) << (k % 4)));
            if (k >= 2) begin
                check("rr_out_valid", 32'(out_valid), 32'h1);
                check("rr_out_id", 32'(out_id), 32'((k - 2) % 4));
                check("rr_out_data", out_data, 32'h3F800000 + 32'(((k - 2) % 4) * 16));
            end
            tick();
        end
        in_valid = 4'h0;
        tick(); tick(); tick();

        // Downstream stall: two grants fill S1/S2, then everything holds.
        do_reset(1'b0);
        out_ready = 1'b0;
        in_valid  = 4'hF;
        grants    = 0;
        held      = '0;
        for (int k = 0; k < 5; k++) begin
            settle();
            grants += $countones(in_ready);
            if (k == 2) held = out_data;
            if (k > 2) check("stall_data_stable", out_data, held);
            if (k == 4) check("stall_in_ready", 32'(in_ready), 32'h0);
            tick();
        end
        check("stall_grants", 32'(grants), 32'd2);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            check("stall_rel_valid", 32'(out_valid), 32'h1);
            check("stall_rel_id", 32'(out_id), 32'(k));
            tick();
        end
        in_valid = 4'h0;
        tick(); tick(); tick();

        // Reset with both stages full discards them; pointer returns to 0.
        do_reset(1'b0);
        out_ready = 1'b0;
        in_valid  = 4'hF;
        tick(); tick(); tick();
        resetn = 1'b0;
        settle();
        check("midrst_in_ready", 32'(in_ready), 32'h0);
        tick();
        resetn    = 1'b1;
        in_valid  = 4'b1101;
        out_ready = 1'b1;
        settle();
        check("midrst_out_valid", 32'(out_valid), 32'h0);
        check("midrst_grant", 32'(in_ready), 32'h1);
        tick();
        in_valid = 4'h0;
        settle();
        check("midrst_no_stale", 32'(out_valid), 32'h0);
        tick();
        settle();
        check("midrst_new_valid", 32'(out_valid), 32'h1);
        check("midrst_new_id", 32'(out_id), 32'h0);
        tick();
        settle();
        check("midrst_drained", 32'(out_valid), 32'h0);

        // Randomized traffic against an occupancy/ordering model.
        do_reset(1'b0);
        pv = '0;
        for (int i = 0; i < 4; i++) begin
            pd[i] = '0; pt[i] = '0; ps[i] = 1'b0; pn[i] = 1'b0;
        end
        ptr        = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_id    = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pv[i] && $urandom_range(0, 1) == 1) begin
                    pd[i] = $urandom;
                    c = int'($urandom_range(0, 3));
                    if (c == 0) pd[i][22:0] = '1;
                    if (c == 1) begin pd[i][30:23] = 8'hFE; pd[i][22:0] = '1; end
                    pt[i] = 2'($urandom_range(0, 3));
                    ps[i] = 1'($urandom_range(0, 1));
                    pn[i] = ($urandom_range(0, 7) == 0);
                    pv[i] = 1'b1;
                end
                set_req(i, pd[i], pt[i], ps[i], pn[i]);
            end
            in_valid  = pv;
            out_ready = ($urandom_range(0, 3) != 0);
            settle();

            accept = (q.size() < 2) || out_ready;
            found  = 1'b0;
            g      = 0;
            for (int k = 0; k < 4; k++) begin
                c = (ptr + k) % 4;
                if (!found && pv[c]) begin found = 1'b1; g = c; end
            end
            exp_ready = (accept && found) ? (4'(1) << g) : 4'h0;
            check("rnd_in_ready", 32'(in_ready), 32'(exp_ready));

            if (prev_stall) begin
                check("rnd_hold_valid", 32'(out_valid), 32'h1);
                check("rnd_hold_data", out_data, prev_data);
                check("rnd_hold_id", 32'(out_id), 32'(prev_id));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("rnd_unexpected_out", 32'(out_valid), 32'h0);
                end else begin
                    t = q.pop_front();
                    check("rnd_out_data", out_data, t.data);
                    check("rnd_out_id", 32'(out_id), 32'(t.id));
                end
            end
            if (exp_ready != 4'h0) begin
                t.data = ref_round(pd[g], pt[g], ps[g], pn[g]);
                t.id   = 2'(g);
                q.push_back(t);
                pv[g] = 1'b0;
                ptr   = (g + 1) % 4;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_id    = out_id;
            tick();
        end

        pv        = '0;
        in_valid  = 4'h0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("drain_unexpected_out", 32'(out_valid), 32'h0);
                end else begin
                    t = q.pop_front();
                    check("drain_out_data", out_data, t.data);
                    check("drain_out_id", 32'(out_id), 32'(t.id));
                end
            end
            tick();
        end
        check("drain_empty", 32'(q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/float_round_arbiter.md
FLOAT_ROUND_ARBITER -- requirements
Module: float_round_arbiter

Interface
REQ-001 Parameter EXP, default 8, exponent field width.
REQ-002 Parameter FRAC, default 23, fraction field width.
REQ-003 Parameter NUM_REQ, default 4, requester count, 2..16; IDW = max(1, $clog2(NUM_REQ)).
REQ-004 The block SHALL use one clock and a synchronous, active-low reset, with ports as listed below.
REQ-005 Port clock  input  1  sole clock, rising edge.
REQ-006 Port resetn  input  1  synchronous active-low reset.
REQ-007 Port in_valid  input  NUM_REQ  per-requester request valid.
REQ-008 Port in_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
REQ-009 Port in_data  input  NUM_REQ*(1+EXP+FRAC)  unrounded float, slice i = {sign, exponent, fraction}.
REQ-010 Port in_trailing  input  NUM_REQ*2  slice i = {guard, round}.
REQ-011 Port in_sticky  input  NUM_REQ  sticky bit per requester.
REQ-012 Port in_is_nan  input  NUM_REQ  input is inf/NaN, pass fraction through.
REQ-013 Port out_valid  output  1  rounded result valid.
REQ-014 Port out_ready  input  1  downstream accept.
REQ-015 Port out_data  output  1+EXP+FRAC  rounded float.
REQ-016 Port out_id  output  IDW  index of originating requester.

Function
REQ-017 Two register stages SHALL exist: capture stage S1 and result stage S2, each with a valid bit.
REQ-018 Transfer SHALL occur on a port when valid and ready are both high at a rising edge.
REQ-019 S2 SHALL load from S1 when S1 is valid and (S2 is empty or out_ready is high).
REQ-020 S1 SHALL accept a new request when S1 is empty or S1 moves to S2 in the same cycle.
REQ-021 in_ready SHALL be combinational from in_valid, the RR pointer and S1 acceptance; zero when S1 cannot accept.
REQ-022 Arbitration SHALL be round-robin: grant the first valid requester at or after index ptr, wrapping NUM_REQ-1 to 0.
REQ-023 On a grant to index g, ptr SHALL become (g+1) mod NUM_REQ; otherwise ptr SHALL hold.
REQ-024 Latency from accepted request to out_valid SHALL be 2 cycles when out_ready is held high.
REQ-025 Throughput SHALL be one result per cycle with out_ready held high.
REQ-026 With out_ready low, out_data and out_id SHALL be held stable while out_valid is high.
REQ-027 Rounding SHALL be computed on the S1 contents and registered into S2.
REQ-028 Round up is r = guard & (round | sticky | fraction[0]).
REQ-029 Define sum = {exponent, fraction} + r, EXP+FRAC bits, with carry discarded.
REQ-030 Output sign SHALL equal the input sign.
REQ-031 Output exponent SHALL be sum[EXP+FRAC-1:FRAC].
REQ-032 Output fraction SHALL be the input fraction if is_nan is set.
REQ-033 Otherwise, output fraction SHALL be 0 if the output exponent is all ones (overflow to inf).
REQ-034 Otherwise, output fraction SHALL be sum[FRAC-1:0].
REQ-035 A fraction carry SHALL propagate into the exponent (e.g. 1.111..1 rounds to next binade).
REQ-036 Requester payloads not granted SHALL be ignored; a requester SHALL hold its payload until in_ready.

Reset
REQ-037 When resetn is low at a clock edge, S1 valid, S2 valid and out_valid SHALL be 0, and ptr SHALL be 0.
REQ-038 While resetn is low, in_ready SHALL be all zero.
REQ-039 During reset, out_data and out_id SHALL be 0.
REQ-040 Reset mid-operation SHALL discard in-flight results with no output after release.
REQ-041 The first grant after reset SHALL go to the lowest-index valid requester.

Verification (EXP=8, FRAC=23, NUM_REQ=4)
REQ-042 The bench SHALL cover: req0 0x3F800001, trailing 2'b10, sticky 0 -> out 0x3F800002, out_id 0, 2 cycles later.
REQ-043 The bench SHALL cover: req1 0x3F800000, trailing 2'b10, sticky 0 -> out 0x3F800000 (tie to even); with sticky 1 -> 0x3F800001.
REQ-044 The bench SHALL cover: 0x7F7FFFFF, trailing 2'b11, is_nan 0 -> 0x7F800000; 0x7FC00000, trailing 2'b11, is_nan 1 -> 0x7FC00000.
REQ-045 The bench SHALL cover: all four valid, out_ready 1 -> out_id 0,1,2,3,0 on consecutive cycles, and each in_ready one-hot.
REQ-046 The bench SHALL cover: out_ready 0 for 5 cycles with all valid -> exactly 2 grants, then in_ready 0 and out_data stable; on release, ordering is preserved.
REQ-047 The bench SHALL cover: resetn low for 1 cycle with S1 and S2 full -> out_valid 0 next cycle, and the next grant goes to the lowest valid index.
